// File: rtl/sd_adc_pkg.sv
// Shared defaults and types for the first-order sigma-delta ADC.
//   DECIM_LOG2_DEF  : default log2 of the decimation window (clk cycles)
//   SYNC_STAGES_DEF : default depth of the comparator synchroniser
//   out_w_f()       : sample width that can hold 0..2^decim_log2 inclusive
//   sample_t        : sample word for the default configuration
package sd_adc_pkg;

    localparam int unsigned DECIM_LOG2_DEF  = 10;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // One extra bit because a window of all ones counts to exactly 2^decim_log2.
    function automatic int unsigned out_w_f(input int unsigned decim_log2);
        return decim_log2 + 1;
    endfunction

    localparam int unsigned OUT_W_DEF = DECIM_LOG2_DEF + 1;

    typedef logic [OUT_W_DEF-1:0] sample_t;

endpackage

// File: rtl/sync_ff.sv
// N-stage flop synchroniser with synchronous active-low reset.
// Reusable for any asynchronous level input (comparator, buttons).
//   clk    : destination clock
//   resetn : synchronous reset, active-low; clears every stage
//   d_i    : asynchronous input
//   q_o    : synchronised output, STAGES cycles behind d_i
module sync_ff #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;
    logic [STAGES-1:0][WIDTH-1:0] chain_d;

    // Shift the input in at stage 0; every stage takes its predecessor.
    always_comb begin
        chain_d    = chain_q;
        chain_d[0] = d_i;
        for (int i = 1; i < int'(STAGES); i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/sigma_delta_adc.sv
// First-order sigma-delta ADC back end: synchronises the comparator bit,
// returns it as the loop feedback and decimates the bitstream with an
// accumulate-and-dump counter into a one-deep valid/ready sample register.
//   clk          : system clock
//   resetn       : synchronous reset, active-low
//   comp_in      : raw comparator bit, asynchronous to clk
//   enable       : conversion enable; low abandons the current window
//   fb_out       : quantised bitstream, fed back to the RC integrator
//   sample_data  : ones-count of the last accepted window
//   sample_valid : sample_data holds an unconsumed sample
//   sample_ready : downstream accepts when valid and ready are both high
//   overrun      : sticky, a completed window was dropped
module sigma_delta_adc
    import sd_adc_pkg::*;
#(
    parameter int unsigned DECIM_LOG2  = DECIM_LOG2_DEF,
    parameter int unsigned OUT_W       = out_w_f(DECIM_LOG2),
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             comp_in,
    input  logic             enable,
    output logic             fb_out,
    output logic [OUT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun
);

    logic                  fb_q;
    logic [DECIM_LOG2-1:0] win_q,   win_d;
    logic [OUT_W-1:0]      acc_q,   acc_d;
    logic [OUT_W-1:0]      data_q,  data_d;
    logic                  valid_q, valid_d;
    logic                  ovr_q,   ovr_d;
    logic                  win_end_c;
    logic [OUT_W-1:0]      result_c;

    // Last synchroniser flop doubles as the feedback/quantiser output.
    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (comp_in),
        .q_o    (fb_q)
    );

    // Window counting, dump and one-deep output register.
    always_comb begin
        win_d   = win_q;
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        win_end_c = enable && (win_q == '1);
        // The end cycle's own bit is part of the window, hence acc + fb.
        result_c  = acc_q + OUT_W'(fb_q);

        if (!enable) begin
            win_d = '0;
            acc_d = '0;
        end else begin
            win_d = win_q + DECIM_LOG2'(1);
            acc_d = win_end_c ? '0 : result_c;
        end

        if (win_end_c) begin
            // A same-cycle handshake frees the slot for the new result.
            if (!valid_q || sample_ready) begin
                data_d  = result_c;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            win_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            win_q   <= win_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign fb_out       = fb_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc with a 16-cycle window and 2-flop sync.
module tb_sigma_delta_adc;

    localparam int unsigned DL = 4;
    localparam int unsigned OW = 5;
    localparam int unsigned SS = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          comp_in;
    logic          enable;
    logic          fb_out;
    logic [OW-1:0] sample_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [7:0] pat = 8'b1011_0010;

    always #5 clk = ~clk;

    sigma_delta_adc #(
        .DECIM_LOG2  (DL),
        .OUT_W       (OW),
        .SYNC_STAGES (SS)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .comp_in      (comp_in),
        .enable       (enable),
        .fb_out       (fb_out),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    // Advance one clock and settle; cyc counts edges since the last release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn       = 1'b0;
        comp_in      = 1'b0;
        enable       = 1'b0;
        sample_ready = 1'b0;

        // 1: outputs held at zero in reset while comp_in toggles
        tick();
        for (int i = 0; i < 3; i++) begin
            comp_in = ~comp_in;
            tick();
            chk("rst_fb",    32'(fb_out),       32'd0);
            chk("rst_data",  32'(sample_data),  32'd0);
            chk("rst_valid", 32'(sample_valid), 32'd0);
            chk("rst_ovr",   32'(overrun),      32'd0);
        end
        resetn = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            comp_in = pat[i];
            tick();
            if (i >= 1) chk("fb_track", 32'(fb_out), 32'(pat[i-1]));
        end

        // 2: constant ones, always ready
        resetn = 1'b0;
        tick();
        resetn       = 1'b1;
        enable       = 1'b1;
        comp_in      = 1'b1;
        sample_ready = 1'b1;
        cyc          = -1;
        tick();
        chk("ones_fb0", 32'(fb_out), 32'd0);
        tick();
        chk("ones_fb1", 32'(fb_out), 32'd1);
        ticks(13);
        chk("ones_nv14", 32'(sample_valid), 32'd0);
        tick();
        chk("ones_v15",   32'(sample_valid), 32'd1);
        chk("ones_first", 32'(sample_data),  32'd14);
        chk("ones_ovr15", 32'(overrun),      32'd0);
        tick();
        chk("ones_pulse", 32'(sample_valid), 32'd0);
        ticks(14);
        chk("ones_nv30", 32'(sample_valid), 32'd0);
        tick();
        chk("ones_v31",   32'(sample_valid), 32'd1);
        chk("ones_full",  32'(sample_data),  32'd16);
        tick();
        chk("ones_nv32",  32'(sample_valid), 32'd0);
        chk("ones_ovr32", 32'(overrun),      32'd0);

        // 3: alternating bitstream, half-scale
        while (cyc < 79) begin
            comp_in = ~comp_in;
            tick();
            if (cyc == 63 || cyc == 79) begin
                chk("alt_valid", 32'(sample_valid), 32'd1);
                chk("alt_data",  32'(sample_data),  32'd8);
            end
        end

        // 4: downstream stalled for 40 cycles
        resetn = 1'b0;
        tick();
        resetn       = 1'b1;
        comp_in      = 1'b1;
        sample_ready = 1'b0;
        enable       = 1'b1;
        cyc          = -1;
        ticks(16);
        chk("stall_v15",   32'(sample_valid), 32'd1);
        chk("stall_d15",   32'(sample_data),  32'd14);
        chk("stall_ovr15", 32'(overrun),      32'd0);
        ticks(15);
        chk("stall_ovr30", 32'(overrun),      32'd0);
        chk("stall_v30",   32'(sample_valid), 32'd1);
        tick();
        chk("stall_ovr31", 32'(overrun),      32'd1);
        chk("stall_d31",   32'(sample_data),  32'd14);
        chk("stall_v31",   32'(sample_valid), 32'd1);
        ticks(8);
        sample_ready = 1'b1;
        tick();
        chk("stall_acc_v", 32'(sample_valid), 32'd0);
        chk("stall_acc_d", 32'(sample_data),  32'd14);
        ticks(7);
        chk("stall_v47",   32'(sample_valid), 32'd1);
        chk("stall_d47",   32'(sample_data),  32'd16);
        chk("stall_ovr47", 32'(overrun),      32'd1);
        tick();
        chk("stall_nv48",  32'(sample_valid), 32'd0);

        // 5: ready only on the window-end cycle while a sample is pending
        resetn = 1'b0;
        tick();
        resetn       = 1'b1;
        sample_ready = 1'b0;
        cyc          = -1;
        ticks(16);
        chk("wend_v15", 32'(sample_valid), 32'd1);
        chk("wend_d15", 32'(sample_data),  32'd14);
        ticks(15);
        sample_ready = 1'b1;
        tick();
        chk("wend_v31",   32'(sample_valid), 32'd1);
        chk("wend_d31",   32'(sample_data),  32'd16);
        chk("wend_ovr31", 32'(overrun),      32'd0);
        sample_ready = 1'b0;
        tick();
        chk("wend_v32", 32'(sample_valid), 32'd1);
        chk("wend_d32", 32'(sample_data),  32'd16);

        // 6: enable dropped at win=7 for 5 cycles with a sample pending
        ticks(6);
        enable = 1'b0;
        ticks(2);
        chk("dis_pend_v", 32'(sample_valid), 32'd1);
        chk("dis_pend_d", 32'(sample_data),  32'd16);
        sample_ready = 1'b1;
        tick();
        chk("dis_acc_v", 32'(sample_valid), 32'd0);
        chk("dis_acc_d", 32'(sample_data),  32'd16);
        sample_ready = 1'b0;
        ticks(2);
        enable = 1'b1;
        ticks(15);
        chk("dis_nv58", 32'(sample_valid), 32'd0);
        tick();
        chk("dis_v59",   32'(sample_valid), 32'd1);
        chk("dis_d59",   32'(sample_data),  32'd16);
        chk("dis_ovr59", 32'(overrun),      32'd0);

        // 6b: reset pulse with a sample pending
        resetn = 1'b0;
        tick();
        chk("rp_valid", 32'(sample_valid), 32'd0);
        chk("rp_data",  32'(sample_data),  32'd0);
        chk("rp_ovr",   32'(overrun),      32'd0);
        chk("rp_fb",    32'(fb_out),       32'd0);
        resetn = 1'b1;
        cyc    = -1;
        ticks(15);
        chk("rp_nv14", 32'(sample_valid), 32'd0);
        tick();
        chk("rp_v15", 32'(sample_valid), 32'd1);
        chk("rp_d15", 32'(sample_data),  32'd14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sigma_delta_adc.md
Name: sigma_delta_adc

Overview:
- Consumes the LVDS comparator bit (`comp_in`) produced by the differential input buffer.
- Closes a first-order sigma-delta loop by driving the synchronised bit back out on `fb_out`, which goes to the external RC integrator.
- Decimates the bitstream with an accumulate-and-dump counter over a 2^DECIM_LOG2-cycle window.
- Presents each result as a sample on a one-deep valid/ready output register for downstream DSP or UART stages.

Parameters:
- DECIM_LOG2, 10: log2 of the decimation window length in clk cycles.
- OUT_W, DECIM_LOG2+1: width of `sample_data`; holds the range 0..2^DECIM_LOG2.
- SYNC_STAGES, 2: number of flops synchronising `comp_in`; minimum 2.

Ports:
- clk  in  1  system clock (HFOSC domain).
- resetn  in  1  synchronous reset, active-low.
- comp_in  in  1  raw comparator bit, asynchronous to clk.
- enable  in  1  conversion enable.
- fb_out  out  1  feedback bit to the RC integrator; this is the quantised bitstream.
- sample_data  out  OUT_W  ones-count of the last completed window.
- sample_valid  out  1  `sample_data` holds an unconsumed sample.
- sample_ready  in  1  downstream accepts the sample when `sample_valid` and `sample_ready` are both high.
- overrun  out  1  sticky flag: a completed window was dropped.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (`resetn`, sampled on posedge clk). While `resetn`=0:
  - every flop clears;
  - `fb_out`=0, `sample_data`=0, `sample_valid`=0, `overrun`=0;
  - the sync chain, the window counter `win` and the accumulator `acc` clear.
- Sync chain:
  - `comp_in` passes through SYNC_STAGES flops.
  - `fb_out` is the last flop of the chain, so latency from `comp_in` to `fb_out` is SYNC_STAGES cycles.
  - The chain runs regardless of `enable`.
- Window counter `win` (DECIM_LOG2 bits):
  - When `enable`=1, it increments every cycle and wraps from 2^DECIM_LOG2-1 to 0.
  - The cycle with `win`=all-ones is the window end.
- Accumulator `acc` (OUT_W bits):
  - On a non-end cycle: `acc` <= `acc` + `fb_out`.
  - On the window end: the window result is `acc` + `fb_out`, and `acc` <= 0.
  - The count is exact; `acc` never saturates because the maximum is 2^DECIM_LOG2, which fits in OUT_W.
- Output register (one deep):
  - At window end, if `sample_valid`=0, or `sample_valid` & `sample_ready` in the same cycle: `sample_data` <= result and `sample_valid` <= 1 on the next cycle. The sample appears 1 cycle after the window end.
  - At window end, if `sample_valid`=1 and `sample_ready`=0: the result is discarded, `sample_data` keeps the old value, and `overrun` <= 1.
  - `overrun` is cleared only by reset.
  - Handshake without a window end: `sample_valid` <= 0 on the next cycle; `sample_data` keeps its value.
  - `sample_data` is stable while `sample_valid`=1 and not yet accepted.
- enable=0:
  - `win` and `acc` are forced to 0 every cycle, so a partial window is abandoned.
  - No new samples are produced.
  - A pending sample stays valid and consumable.
  - When `enable` returns to 1, a full window starts on that cycle (`win`=0).
- Reset mid-window or with a sample pending: everything clears and the pending sample is lost. This is legal and intended.

Decomposition:
- Package `sd_adc_pkg`: DECIM_LOG2 default, an OUT_W helper function, the SYNC_STAGES default, and a typedef for the sample word.
- One sub-module, `sync_ff`: a parameterised N-stage synchroniser with synchronous active-low reset. It is reusable for the button inputs.
- Window counter, accumulator and output register stay in `sigma_delta_adc`.

Test Plan:
All scenarios use DECIM_LOG2=4 (16-cycle window, OUT_W=5) and SYNC_STAGES=2.
1. Hold `resetn`=0 for 3 cycles with `comp_in` toggling. Required: all outputs 0 throughout. Release with `enable`=1: `fb_out` tracks `comp_in` 2 cycles later.
2. `comp_in`=1 constant, `sample_ready`=1, `enable`=1 from the reset release cycle. Required: the first sample is 14 (2 sync-latency zeros); subsequent samples are 16; `sample_valid` pulses 1 cycle every 16; `overrun` stays 0.
3. `comp_in` alternates 1/0 each cycle, in steady state, with `sample_ready`=1. Required: each sample is 8.
4. `comp_in`=1, `sample_ready`=0 for 40 cycles. Required:
   - the first sample (14) is held with `sample_valid`=1;
   - `overrun`=1 the cycle after the second window end, and `sample_data` is still 14;
   - after `sample_ready` rises, the next window delivers 16; `overrun` stays 1.
5. `sample_ready` pulsed only on the window-end cycle while a sample is pending. Required: the new sample loads, `sample_valid` stays 1, and `overrun` stays 0.
6. `enable` dropped at `win`=7 for 5 cycles with a sample pending, then raised. Required:
   - the pending sample is still delivered on `sample_ready`;
   - the next sample counts exactly the 16 cycles after `enable` rises (16 with `comp_in`=1).

   Repeat with `resetn` pulsed low instead of `enable`. Required: `sample_valid` drops immediately at the next edge.
